// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, one-word-per-line data cache controller.
// Owns the line array and sequences writeback/refill over a four-phase syn/ack RAM handshake.
module dm_cache_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int INDEX_BITS = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_busy,
    output logic              ram_syn,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_REL,
        RF_REQ,
        RF_REL,
        RESP
    } stateT;

    stateT state;

    logic [LINES-1:0]  lineValid;
    logic [LINES-1:0]  lineDirty;
    logic [TAG_W-1:0]  lineTag  [LINES];
    logic [DATA_W-1:0] lineData [LINES];

    logic              reqWrite;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata;
    logic [15:0]       hitCount;
    logic [15:0]       missCount;

    logic [INDEX_BITS-1:0] reqIndex;
    logic [TAG_W-1:0]      reqTag;
    logic                  lookupHit;
    logic                  victimDirty;

    always_comb begin
        reqIndex    = reqAddr[INDEX_BITS-1:0];
        reqTag      = reqAddr[ADDR_W-1:INDEX_BITS];
        lookupHit   = lineValid[reqIndex] && (lineTag[reqIndex] == reqTag);
        victimDirty = lineValid[reqIndex] && lineDirty[reqIndex];
    end

    assign hit_count  = hitCount;
    assign miss_count = missCount;

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            lineValid <= '0;
            lineDirty <= '0;
            ram_syn   <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            cpu_busy  <= 1'b0;
            hitCount  <= '0;
            missCount <= '0;
            reqWrite  <= 1'b0;
            reqAddr   <= '0;
            reqWdata  <= '0;
        end else begin
            cpu_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        reqWrite <= cpu_write;
                        reqAddr  <= cpu_addr;
                        reqWdata <= cpu_wdata;
                        cpu_busy <= 1'b1;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookupHit) begin
                        if (hitCount != '1) hitCount <= hitCount + 16'd1;
                        if (reqWrite) begin
                            lineDirty[reqIndex] <= 1'b1;
                            lineData[reqIndex]  <= reqWdata;
                        end else begin
                            cpu_rdata <= lineData[reqIndex];
                        end
                        cpu_done <= 1'b1;
                        state    <= RESP;
                    end else begin
                        if (missCount != '1) missCount <= missCount + 16'd1;
                        if (victimDirty) begin
                            ram_addr  <= {lineTag[reqIndex], reqIndex};
                            ram_wdata <= lineData[reqIndex];
                            ram_write <= 1'b1;
                            state     <= WB_REQ;
                        end else if (reqWrite) begin
                            // One-word lines: a write miss overwrites the whole line, no refill needed.
                            lineValid[reqIndex] <= 1'b1;
                            lineDirty[reqIndex] <= 1'b1;
                            lineTag[reqIndex]   <= reqTag;
                            lineData[reqIndex]  <= reqWdata;
                            cpu_done            <= 1'b1;
                            state               <= RESP;
                        end else begin
                            ram_addr  <= reqAddr;
                            ram_write <= 1'b0;
                            state     <= RF_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    // Strobe only once any stale ack is low; a high ack only completes our own strobe.
                    if (ram_syn && ram_ack) begin
                        ram_syn <= 1'b0;
                        state   <= WB_REL;
                    end else begin
                        ram_syn <= !ram_ack;
                    end
                end
                WB_REL: begin
                    if (!ram_ack) begin
                        lineDirty[reqIndex] <= 1'b0;
                        if (reqWrite) begin
                            lineValid[reqIndex] <= 1'b1;
                            lineDirty[reqIndex] <= 1'b1;
                            lineTag[reqIndex]   <= reqTag;
                            lineData[reqIndex]  <= reqWdata;
                            cpu_done            <= 1'b1;
                            state               <= RESP;
                        end else begin
                            ram_addr  <= reqAddr;
                            ram_write <= 1'b0;
                            state     <= RF_REQ;
                        end
                    end
                end
                RF_REQ: begin
                    if (ram_syn && ram_ack) begin
                        lineValid[reqIndex] <= 1'b1;
                        lineDirty[reqIndex] <= 1'b0;
                        lineTag[reqIndex]   <= reqTag;
                        lineData[reqIndex]  <= ram_rdata;
                        cpu_rdata           <= ram_rdata;
                        ram_syn             <= 1'b0;
                        state               <= RF_REL;
                    end else begin
                        ram_syn <= !ram_ack;
                    end
                end
                RF_REL: begin
                    if (!ram_ack) begin
                        cpu_done <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    cpu_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
